controladora_multicanal: RTL

//   N-channel lamp controller: per channel, debounced push button, IR presence sensor, lamp output and mode LED.

---
 rtl/controladora_pkg.sv | 14 +
 rtl/controladora_canal.sv | 105 ++++++++++
 rtl/controladora_multicanal.sv | 53 +++++
 3 files changed

// File: rtl/controladora_pkg.sv
// Shared types and helpers for the multi-channel lamp controller.
package controladora_pkg;

  typedef enum logic {
    MODO_AUTO   = 1'b0,
    MODO_MANUAL = 1'b1
  } modo_t;

  // Bits needed to hold any value from 0 up to and including max.
  function automatic int cnt_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/controladora_canal.sv
// One lamp channel: input synchronisers, press counter, AUTO/MANUAL mode FSM,
// shared hold/inactivity timer and the registered lamp drive.
module controladora_canal
  import controladora_pkg::*;
#(
  parameter int DEBOUNCE_P        = 300,
  parameter int SWITCH_MODE_MIN_T = 5300,
  parameter int AUTO_SHUTDOWN_T   = 30000
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push_button,
  input  logic  infravermelho,
  input  logic  apagar_tudo,
  output logic  saida,
  output modo_t modo
);

  localparam int PW = cnt_w(SWITCH_MODE_MIN_T);
  localparam int TW = cnt_w(AUTO_SHUTDOWN_T);
  localparam logic [PW-1:0] PRESS_MAX  = PW'(SWITCH_MODE_MIN_T);
  localparam logic [PW-1:0] PRESS_LONG = PW'(SWITCH_MODE_MIN_T - 1);
  localparam logic [PW-1:0] PRESS_MIN  = PW'(DEBOUNCE_P);
  localparam logic [PW-1:0] PRESS_ONE  = PW'(1);
  localparam logic [TW-1:0] TMR_LOAD   = TW'(AUTO_SHUTDOWN_T);
  localparam logic [TW-1:0] TMR_ONE    = TW'(1);

  logic [1:0]    btn_sync;
  logic [1:0]    ir_sync;
  logic          btn_s;
  logic          ir_s;
  logic [PW-1:0] press_cnt;
  logic [TW-1:0] tmr;
  logic          long_press;
  logic          short_press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_sync <= '0;
      ir_sync  <= '0;
    end else begin
      btn_sync <= {btn_sync[0], push_button};
      ir_sync  <= {ir_sync[0], infravermelho};
    end
  end

  assign btn_s = btn_sync[1];
  assign ir_s  = ir_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      press_cnt <= '0;
    end else if (!btn_s) begin
      press_cnt <= '0;
    end else if (press_cnt != PRESS_MAX) begin
      press_cnt <= press_cnt + PRESS_ONE;
    end
  end

  // Long press fires on the cycle the counter reaches its ceiling, so only once per press.
  assign long_press  = btn_s && (press_cnt == PRESS_LONG);
  assign short_press = !btn_s && (press_cnt >= PRESS_MIN) && (press_cnt < PRESS_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      modo  <= MODO_AUTO;
      saida <= 1'b0;
      tmr   <= '0;
    end else if (apagar_tudo) begin
      saida <= 1'b0;
      tmr   <= '0;
      if (long_press) modo <= (modo == MODO_AUTO) ? MODO_MANUAL : MODO_AUTO;
    end else if (long_press) begin
      if (modo == MODO_AUTO) begin
        modo <= MODO_MANUAL;
        tmr  <= TMR_LOAD;
      end else begin
        modo  <= MODO_AUTO;
        saida <= 1'b0;
        tmr   <= '0;
      end
    end else if (modo == MODO_AUTO) begin
      if (ir_s) begin
        saida <= 1'b1;
        tmr   <= TMR_LOAD;
      end else if (tmr != '0) begin
        tmr <= tmr - TMR_ONE;
        if (tmr == TMR_ONE) saida <= 1'b0;
      end
    end else begin
      if (short_press) saida <= ~saida;
      // In MANUAL the timer only measures inactivity; expiry drops back to AUTO.
      if (ir_s || btn_s) begin
        tmr <= TMR_LOAD;
      end else if (tmr != '0) begin
        tmr <= tmr - TMR_ONE;
        if (tmr == TMR_ONE) begin
          modo  <= MODO_AUTO;
          saida <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/controladora_multicanal.sv
// Room-panel lamp controller: N independent channels sharing only the all-off
// command, plus a registered count of lit lamps.
module controladora_multicanal
  import controladora_pkg::*;
#(
  parameter int N_CANAIS          = 4,
  parameter int DEBOUNCE_P        = 300,
  parameter int SWITCH_MODE_MIN_T = 5300,
  parameter int AUTO_SHUTDOWN_T   = 30000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_CANAIS-1:0]             push_button,
  input  logic [N_CANAIS-1:0]             infravermelho,
  input  logic                            apagar_tudo,
  output logic [N_CANAIS-1:0]             led,
  output logic [N_CANAIS-1:0]             saida,
  output logic [$clog2(N_CANAIS+1)-1:0]   canais_ativos
);

  localparam int AW = $clog2(N_CANAIS + 1);

  modo_t         modo [N_CANAIS];
  logic [AW-1:0] soma;

  for (genvar g = 0; g < N_CANAIS; g++) begin : g_canal
    controladora_canal #(
      .DEBOUNCE_P        (DEBOUNCE_P),
      .SWITCH_MODE_MIN_T (SWITCH_MODE_MIN_T),
      .AUTO_SHUTDOWN_T   (AUTO_SHUTDOWN_T)
    ) u_canal (
      .clk           (clk),
      .rst           (rst),
      .push_button   (push_button[g]),
      .infravermelho (infravermelho[g]),
      .apagar_tudo   (apagar_tudo),
      .saida         (saida[g]),
      .modo          (modo[g])
    );
    assign led[g] = (modo[g] == MODO_MANUAL);
  end

  always_comb begin
    soma = '0;
    for (int k = 0; k < N_CANAIS; k++) soma = soma + AW'(saida[k]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) canais_ativos <= '0;
    else      canais_ativos <= soma;
  end

endmodule
